// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the execute stage and the iterative mul/div engine.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             mf_req;
  logic             mf_sel;
  logic [WIDTH-1:0] mf_value;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mf_req, mf_sel,
    input  mf_value, busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mf_req, mf_sel,
    output mf_value, busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO result registers.
// Build option MULDIV_SIGNED_EN enables signed MULT/DIV selected by op[0].
//
// state  | meaning
// IDLE   | waiting for start; mf reads served from hi/lo
// RUN    | one multiply/divide iteration per cycle, WIDTH cycles
// FINISH | sign correction, hi/lo written, done pulsed next cycle
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input logic              clock,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div, dz;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq, md;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, dz_r;
  logic             start_dz;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod = {acc[WIDTH-1:0], mq};

`ifdef MULDIV_SIGNED_EN
  logic sign_a, sign_b;

  assign mag_a    = (bus.op[0] & bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign mag_b    = (bus.op[0] & bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  assign quo_fix  = (sign_a ^ sign_b) ? -mq : mq;
  assign rem_fix  = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sign_a <= bus.op[0] & bus.operand_a[WIDTH-1];
      sign_b <= bus.op[0] & bus.operand_b[WIDTH-1];
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = bus.op[0];
  assign mag_a      = bus.operand_a;
  assign mag_b      = bus.operand_b;
  assign prod_fix   = prod;
  assign quo_fix    = mq;
  assign rem_fix    = acc[WIDTH-1:0];
`endif

  // acc is one bit wider than a half result so the carry/borrow is visible
  assign add_sum  = acc + (mq[0] ? {1'b0, md} : '0);
  assign rem_sh   = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, md};
  assign start_dz = bus.op[1] & (bus.operand_b == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.stall = bus.busy & (bus.start | bus.mf_req);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      md     <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= CW'(WIDTH - 1);
            is_div <= bus.op[1];
            dz     <= start_dz;
            acc    <= '0;
            if (bus.op[1]) begin
              md <= mag_b;
              // a zero divisor keeps the raw dividend so it lands in hi untouched
              mq <= start_dz ? bus.operand_a : mag_a;
            end else begin
              md <= mag_a;
              mq <= mag_b;
            end
          end
        end
        RUN: begin
          if (!dz) begin
            if (is_div) begin
              if (!diff[WIDTH]) begin
                acc <= diff;
                mq  <= {mq[WIDTH-2:0], 1'b1};
              end else begin
                acc <= rem_sh;
                mq  <= {mq[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= {1'b0, add_sum[WIDTH:1]};
              mq  <= {add_sum[0], mq[WIDTH-1:1]};
            end
          end
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FINISH: begin
          done_r <= 1'b1;
          dz_r   <= dz;
          if (dz) begin
            hi_r <= mq;
            lo_r <= '1;
          end else if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.mf_value = bus.mf_sel ? hi_r : lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, hazards, reset abort.
module tb_muldiv_sequencer;
  localparam int WIDTH = 16;

  logic clock = 1'b0;
  logic reset;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();
  muldiv_sequencer #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("hi", bus.hi, e.hi);
          check("lo", bus.lo, e.lo);
          check("div_zero", bus.div_zero, e.dz);
          check("latency", cyc - e.acc, 17);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                       input logic exp_dz, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    while (bus.busy && n < 40) begin
      check("stall_on_start", bus.stall, 1'b1);
      n++;
      @(negedge clock);
    end
    check("issue_timeout", bus.busy, 1'b0);
    @(posedge clock);
    #1;
    acc = cyc;
    e.hi = exp_hi;
    e.lo = exp_lo;
    e.dz = exp_dz;
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic wait_idle(output int n);
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    int acc_a, acc_b, n;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.mf_req = 1'b0;
    bus.mf_sel = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_div_zero", bus.div_zero, 1'b0);
    check("rst_hi", bus.hi, 16'h0000);
    check("rst_lo", bus.lo, 16'h0000);
    check("rst_mf_value", bus.mf_value, 16'h0000);
    reset = 1'b0;
    bus.mf_req = 1'b1;
    #1;
    check("idle_no_stall", bus.stall, 1'b0);
    bus.mf_req = 1'b0;

    issue(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, acc_a);
    wait_idle(n);
    check("busy_cycles_multu", n, 17);
    bus.mf_sel = 1'b0;
    #1 check("mf_lo", bus.mf_value, 16'h0001);
    bus.mf_sel = 1'b1;
    #1 check("mf_hi", bus.mf_value, 16'hFFFE);

`ifdef MULDIV_SIGNED_EN
    issue(2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, acc_a);
    wait_idle(n);
    issue(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, acc_a);
    wait_idle(n);
`else
    issue(2'b01, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF1, 1'b0, acc_a);
    wait_idle(n);
    issue(2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, acc_a);
    wait_idle(n);
`endif
    issue(2'b10, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0, acc_a);
    wait_idle(n);
    issue(2'b10, 16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1, acc_a);
    wait_idle(n);
    check("busy_cycles_divzero", n, 17);

    // move-from-HI hazard two cycles after start
    issue(2'b00, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, acc_a);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b1;
    #1 check("mf_old_hi_during_busy", bus.mf_value, 16'h0064);
    n = 0;
    do begin
      check("stall_mf", bus.stall, 1'b1);
      @(negedge clock);
      n++;
    end while (bus.busy && n < 40);
    check("stall_mf_released", bus.stall, 1'b0);
    check("mf_new_hi", bus.mf_value, 16'h0001);
    bus.mf_req = 1'b0;

    // back-to-back: second start held while busy, accepted right after
    issue(2'b10, 16'h03E8, 16'h000A, 16'h0000, 16'h0064, 1'b0, acc_a);
    issue(2'b00, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0, acc_b);
    check("b2b_accept_gap", acc_b - acc_a, 18);
    wait_idle(n);
    check("busy_cycles_b2b", n, 17);

    // reset in the middle of RUN
    issue(2'b00, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, acc_a);
    @(negedge clock);
    bus.start = 1'b0;
    bus.mf_req = 1'b1;
    repeat (7) @(negedge clock);
    check("busy_before_reset", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_stall", bus.stall, 1'b0);
    check("abort_hi", bus.hi, 16'h0000);
    check("abort_lo", bus.lo, 16'h0000);
    check("abort_done", bus.done, 1'b0);
    sb.delete();
    bus.mf_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    check("no_done_after_abort", bus.done, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative 16-bit multiply/divide engine with its own HI/LO result registers, placed beside the execute-stage ALU of the 16-bit pipelined CPU. It accepts one mul/div request from execute and runs a shift-add (multiply) or restoring (divide) loop for WIDTH cycles. While busy, it stalls the pipeline whenever a younger instruction needs it: a new mul/div or a move-from-HI/LO. Once done, it serves the move-from reads.

## Interface
- WIDTH, 16, operand/result half width; iteration count equals WIDTH.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  execute stage holds a mul/div instruction this cycle.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  in  WIDTH  rs value (multiplicand / dividend).
- operand_b  in  WIDTH  rt value (multiplier / divisor).
- mf_req  in  1  execute stage holds MFHI/MFLO.
- mf_sel  in  1  0 = LO, 1 = HI.
- mf_value  out  WIDTH  selected HI or LO, combinational from the registers.
- busy  out  1  a loop is in progress.
- stall  out  1  equals busy & (start | mf_req); drives stall_F/stall_D and the E hold.
- done  out  1  one-cycle pulse when HI/LO have just been updated.
- div_zero  out  1  qualified by done; the last op was a divide by zero.
- hi, lo  out  WIDTH  result registers; MUL gives {hi,lo} = product, DIV gives lo = quotient and hi = remainder.

## Operation
- FSM states are IDLE, RUN and FINISH.
- IDLE, start=1: latch op and operand magnitudes (signed ops only), store sign flags and load the counter with WIDTH-1. Go to RUN.
- IDLE, start=0: no change.
- RUN: one iteration per cycle.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper accumulator, then shift the {acc, multiplier} pair right by 1.
  - Divide: shift the {rem, quot} pair left by 1, trial-subtract the divisor from rem, and on no borrow keep the difference and set the quotient LSB.
  - When counter = 0, go to FINISH; otherwise decrement the counter.
- FINISH: apply sign correction and write hi/lo, assert done, go to IDLE.
  - Product is negated when sign_a ^ sign_b.
  - Quotient is negated when sign_a ^ sign_b; remainder takes the sign of sign_a.
- Divide by zero: skip the loop. The FSM still passes through RUN for full latency with hi = operand_a and lo = all ones, and div_zero=1 with done.
- Signed overflow (-2^(WIDTH-1) / -1) falls out of the magnitude path: lo = 0x8000 (WIDTH=16), hi = 0. It is not flagged.
- start while busy is not accepted. stall holds the instruction in E, and it is re-presented after busy falls.
- mf_req while busy raises stall. When not busy, mf_value is valid the same cycle.
- Arithmetic: accumulator and remainder are WIDTH+1 bits wide to capture carry/borrow. Magnitudes are unsigned WIDTH-bit values.

## Timing
- Reset values:
  - state = IDLE.
  - busy, stall, done and div_zero = 0.
  - hi and lo = 0.
  - mf_value = 0.
- Latency: start sampled at edge E0 gives busy=1 from after E0 until edge E(WIDTH+1).
  - hi/lo are written at E(WIDTH+1), i.e. E17 for WIDTH=16.
  - done=1 and busy=0 in the cycle after E(WIDTH+1).
- Back-to-back: start in the first cycle after busy falls is accepted, so the next op samples at E(WIDTH+1)+1.
- stall is combinational on busy, start and mf_req. It is never asserted in IDLE.
- hi/lo are stable throughout RUN. mf_value during busy reflects the old values, but stall prevents their use.
- Reset mid-operation aborts immediately: hi/lo are cleared and no done is produced.

## Configuration
- MULDIV_SIGNED_EN defined: op[0] selects signed operation. Magnitude conversion and sign correction are built in.
- MULDIV_SIGNED_EN undefined: op[0] is ignored, so every op is unsigned. The sign logic is removed and FINISH writes the raw results.

## Test plan
- MULTU 0xFFFF × 0xFFFF: after E17, hi=0xFFFE, lo=0x0001, done pulses once, busy high for exactly 17 cycles.
- MULT 0xFFFD (-3) × 0x0005: hi=0xFFFF, lo=0xFFF1.
  - Without MULDIV_SIGNED_EN the same op gives hi=0x0004, lo=0xFFF1.
- DIV 0xFFF9 (-7) / 0x0002: lo=0xFFFD, hi=0xFFFF.
  - DIVU 100 / 7: lo=0x000E, hi=0x0002.
- DIVU 0x0064 / 0: hi=0x0064, lo=0xFFFF, div_zero=1 with done, same 17-cycle latency.
- Hazards:
  - mf_req (mf_sel=1) two cycles after start: stall=1 until busy falls, then mf_value equals the new hi the same cycle.
  - A second start while busy is held and accepted the cycle after busy falls.
- Reset asserted mid-RUN (cycle 8): busy=0, hi=lo=0 immediately, and no done pulse.
